// File: rtl/seq_bin_to_bcd_pkg.sv
// rtl/seq_bin_to_bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package seq_bcd_pkg;

    localparam int BCD_DIGITS  = 3;
    localparam int ADD3_THRESH = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    // Single-digit double-dabble correction; 4-bit wrap is intentional.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'(ADD3_THRESH)) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seq_bin_to_bcd_if.sv
// rtl/seq_bin_to_bcd_if.sv - request/result bundle between converter and its user (blank under SEQ_BCD_LZB_EN)
interface seq_bin_to_bcd_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [3:0]       ones;
    logic [3:0]       tens;
    logic [3:0]       hundreds;
`ifdef SEQ_BCD_LZB_EN
    logic [2:0]       blank;

    modport master (output start, bin,
                    input  ready, busy, done, ones, tens, hundreds, blank);
    modport slave  (input  start, bin,
                    output ready, busy, done, ones, tens, hundreds, blank);
`else
    modport master (output start, bin,
                    input  ready, busy, done, ones, tens, hundreds);
    modport slave  (input  start, bin,
                    output ready, busy, done, ones, tens, hundreds);
`endif
endinterface

// File: rtl/seq_bin_to_bcd_dabble_step.sv
// rtl/seq_bin_to_bcd_dabble_step.sv - combinational add-3 correction applied to every BCD scratch digit
module bcd_dabble_step
    import seq_bcd_pkg::*;
(
    input  logic [4*BCD_DIGITS-1:0] i_digits,
    output logic [4*BCD_DIGITS-1:0] o_digits
);

    always_comb begin
        o_digits = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            o_digits[4*i +: 4] = add3(i_digits[4*i +: 4]);
        end
    end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// rtl/seq_bin_to_bcd.sv - one-bit-per-cycle double-dabble converter; SEQ_BCD_LZB_EN adds leading-zero flags
module seq_bin_to_bcd
    import seq_bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    seq_bin_to_bcd_if.slave   bus
);

    localparam int SCR_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [SCR_W-1:0]   r_scr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [3:0]         r_ones;
    logic [3:0]         r_tens;
    logic [3:0]         r_hund;
`ifdef SEQ_BCD_LZB_EN
    logic [2:0]         r_blank;
`endif

    logic [SCR_W-1:0]       w_adj;
    logic [SCR_W+WIDTH-1:0] w_cat;

    bcd_dabble_step u_step (
        .i_digits (r_scr),
        .o_digits (w_adj)
    );

    // Corrected scratch and shift register move left as one long word.
    assign w_cat = {w_adj, r_sr} << 1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ones  <= '0;
            r_tens  <= '0;
            r_hund  <= '0;
`ifdef SEQ_BCD_LZB_EN
            r_blank <= 3'b110;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sr    <= bus.bin;
                        r_scr   <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_scr <= w_cat[SCR_W+WIDTH-1:WIDTH];
                    r_sr  <= w_cat[WIDTH-1:0];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ones  <= r_scr[3:0];
                    r_tens  <= r_scr[7:4];
                    r_hund  <= r_scr[11:8];
`ifdef SEQ_BCD_LZB_EN
                    r_blank <= {r_scr[11:8] == 4'd0, r_scr[11:4] == 8'd0, 1'b0};
`endif
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready    = r_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.ones     = r_ones;
    assign bus.tens     = r_tens;
    assign bus.hundreds = r_hund;
`ifdef SEQ_BCD_LZB_EN
    assign bus.blank    = r_blank;
`endif

endmodule
